// File: rtl/brisc_pkg.sv
// Shared types and sizing for the brisc memory subsystem.
// Also holds the arbiter's state and requester encodings.
package brisc_pkg;

    localparam int BRISC_ADDRESS_WIDTH    = 32;
    localparam int BRISC_CACHE_LINE_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } mem_arb_state_e;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } mem_requester_e;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: one-hot winner (bit0 = icache, bit1 = dcache)
// and the pointer value to load once a grant is issued.
module rr_pick2
    import brisc_pkg::*;
(
    input  logic           req_ic_in,
    input  logic           req_dc_in,
    input  mem_requester_e ptr_in,
    input  logic           grant_in,
    input  mem_requester_e granted_in,
    output logic [1:0]     winner_out,
    output mem_requester_e ptr_next_out
);

    always_comb begin
        winner_out = 2'b00;
        if (req_ic_in && req_dc_in) begin
            winner_out = (ptr_in == REQ_DC) ? 2'b10 : 2'b01;
        end else if (req_ic_in) begin
            winner_out = 2'b01;
        end else if (req_dc_in) begin
            winner_out = 2'b10;
        end
    end

    // The pointer always hands priority to whoever was not just granted.
    always_comb begin
        ptr_next_out = ptr_in;
        if (grant_in) begin
            ptr_next_out = (granted_in == REQ_IC) ? REQ_DC : REQ_IC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between icache fills and dcache fills/write-backs,
// one line request at a time, and routes read responses back to the issuer.
module mem_arbiter
    import brisc_pkg::*;
#(
    parameter int ADDRESS_WIDTH    = BRISC_ADDRESS_WIDTH,
    parameter int CACHE_LINE_WIDTH = BRISC_CACHE_LINE_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ic_req_in,
    input  logic [ADDRESS_WIDTH-1:0]    ic_addr_in,
    output logic                        ic_grant_out,
    output logic                        ic_fill_out,
    output logic [CACHE_LINE_WIDTH-1:0] ic_fill_data_out,
    output logic [ADDRESS_WIDTH-1:0]    ic_fill_addr_out,
    input  logic                        dc_req_in,
    input  logic [ADDRESS_WIDTH-1:0]    dc_addr_in,
    input  logic [CACHE_LINE_WIDTH-1:0] dc_data_in,
    input  logic                        dc_write_in,
    output logic                        dc_grant_out,
    output logic                        dc_fill_out,
    output logic [CACHE_LINE_WIDTH-1:0] dc_fill_data_out,
    output logic [ADDRESS_WIDTH-1:0]    dc_fill_addr_out,
    output logic                        mem_req_valid_out,
    input  logic                        mem_req_ready_in,
    output logic [ADDRESS_WIDTH-1:0]    mem_req_addr_out,
    output logic [CACHE_LINE_WIDTH-1:0] mem_req_data_out,
    output logic                        mem_req_write_out,
    input  logic                        mem_resp_valid_in,
    input  logic [CACHE_LINE_WIDTH-1:0] mem_resp_data_in,
    input  logic [ADDRESS_WIDTH-1:0]    mem_resp_addr_in,
    output logic                        busy_out
);

    mem_arb_state_e              state_q, state_d;
    mem_requester_e              ptr_q, ptr_d;
    mem_requester_e              owner_q, owner_d;
    logic [ADDRESS_WIDTH-1:0]    addr_q, addr_d;
    logic [CACHE_LINE_WIDTH-1:0] data_q, data_d;
    logic                        write_q, write_d;
    logic [1:0]                  winner;
    logic                        accept;

    assign accept = (state_q == ISSUE) && mem_req_ready_in;

    rr_pick2 u_pick (
        .req_ic_in    (ic_req_in),
        .req_dc_in    (dc_req_in),
        .ptr_in       (ptr_q),
        .grant_in     (accept),
        .granted_in   (owner_q),
        .winner_out   (winner),
        .ptr_next_out (ptr_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= REQ_DC;
            owner_q <= REQ_IC;
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        data_d  = data_q;
        write_d = write_q;
        unique case (state_q)
            IDLE: begin
                if (winner[1]) begin
                    owner_d = REQ_DC;
                    addr_d  = dc_addr_in;
                    data_d  = dc_data_in;
                    write_d = dc_write_in;
                    state_d = ISSUE;
                end else if (winner[0]) begin
                    owner_d = REQ_IC;
                    addr_d  = ic_addr_in;
                    data_d  = '0;
                    write_d = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready_in) begin
                    state_d = write_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid_in) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Fill payload is gated so idle/reset outputs stay at zero.
    always_comb begin
        mem_req_valid_out = 1'b0;
        mem_req_addr_out  = '0;
        mem_req_data_out  = '0;
        mem_req_write_out = 1'b0;
        ic_grant_out      = 1'b0;
        dc_grant_out      = 1'b0;
        ic_fill_out       = 1'b0;
        dc_fill_out       = 1'b0;
        ic_fill_data_out  = '0;
        ic_fill_addr_out  = '0;
        dc_fill_data_out  = '0;
        dc_fill_addr_out  = '0;
        busy_out          = (state_q != IDLE);
        if (state_q == ISSUE) begin
            mem_req_valid_out = 1'b1;
            mem_req_addr_out  = addr_q;
            mem_req_data_out  = data_q;
            mem_req_write_out = write_q;
            ic_grant_out      = accept && (owner_q == REQ_IC);
            dc_grant_out      = accept && (owner_q == REQ_DC);
        end
        if ((state_q == WAIT) && mem_resp_valid_in) begin
            if (owner_q == REQ_DC) begin
                dc_fill_out      = 1'b1;
                dc_fill_data_out = mem_resp_data_in;
                dc_fill_addr_out = mem_resp_addr_in;
            end else begin
                ic_fill_out      = 1'b1;
                ic_fill_data_out = mem_resp_data_in;
                ic_fill_addr_out = mem_resp_addr_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random
// transactions checked against a transaction-level round-robin model.
module tb_mem_arbiter;
    import brisc_pkg::*;

    localparam int AW = BRISC_ADDRESS_WIDTH;
    localparam int DW = BRISC_CACHE_LINE_WIDTH;

    logic          clk;
    logic          reset;
    logic          ic_req_in;
    logic [AW-1:0] ic_addr_in;
    logic          ic_grant_out;
    logic          ic_fill_out;
    logic [DW-1:0] ic_fill_data_out;
    logic [AW-1:0] ic_fill_addr_out;
    logic          dc_req_in;
    logic [AW-1:0] dc_addr_in;
    logic [DW-1:0] dc_data_in;
    logic          dc_write_in;
    logic          dc_grant_out;
    logic          dc_fill_out;
    logic [DW-1:0] dc_fill_data_out;
    logic [AW-1:0] dc_fill_addr_out;
    logic          mem_req_valid_out;
    logic          mem_req_ready_in;
    logic [AW-1:0] mem_req_addr_out;
    logic [DW-1:0] mem_req_data_out;
    logic          mem_req_write_out;
    logic          mem_resp_valid_in;
    logic [DW-1:0] mem_resp_data_in;
    logic [AW-1:0] mem_resp_addr_in;
    logic          busy_out;

    int nChecks = 0;
    int nFail   = 0;
    bit modelPtrDc;

    mem_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .ic_req_in         (ic_req_in),
        .ic_addr_in        (ic_addr_in),
        .ic_grant_out      (ic_grant_out),
        .ic_fill_out       (ic_fill_out),
        .ic_fill_data_out  (ic_fill_data_out),
        .ic_fill_addr_out  (ic_fill_addr_out),
        .dc_req_in         (dc_req_in),
        .dc_addr_in        (dc_addr_in),
        .dc_data_in        (dc_data_in),
        .dc_write_in       (dc_write_in),
        .dc_grant_out      (dc_grant_out),
        .dc_fill_out       (dc_fill_out),
        .dc_fill_data_out  (dc_fill_data_out),
        .dc_fill_addr_out  (dc_fill_addr_out),
        .mem_req_valid_out (mem_req_valid_out),
        .mem_req_ready_in  (mem_req_ready_in),
        .mem_req_addr_out  (mem_req_addr_out),
        .mem_req_data_out  (mem_req_data_out),
        .mem_req_write_out (mem_req_write_out),
        .mem_resp_valid_in (mem_resp_valid_in),
        .mem_resp_data_in  (mem_resp_data_in),
        .mem_resp_addr_in  (mem_resp_addr_in),
        .busy_out          (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] randLine();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " busy"}, busy_out, 0);
        checkOutput({tag, " grants"}, {ic_grant_out, dc_grant_out}, 0);
        checkOutput({tag, " fills"}, {ic_fill_out, dc_fill_out}, 0);
        checkOutput({tag, " ic fill data"}, ic_fill_data_out, 0);
        checkOutput({tag, " ic fill addr"}, ic_fill_addr_out, 0);
        checkOutput({tag, " dc fill data"}, dc_fill_data_out, 0);
        checkOutput({tag, " dc fill addr"}, dc_fill_addr_out, 0);
        checkOutput({tag, " req valid"}, mem_req_valid_out, 0);
        checkOutput({tag, " req addr"}, mem_req_addr_out, 0);
        checkOutput({tag, " req data"}, mem_req_data_out, 0);
        checkOutput({tag, " req write"}, mem_req_write_out, 0);
    endtask

    task automatic applyStimulus();
        ic_req_in         = 1'($urandom());
        ic_addr_in        = $urandom();
        dc_req_in         = 1'($urandom());
        dc_addr_in        = $urandom();
        dc_data_in        = randLine();
        dc_write_in       = 1'($urandom());
        mem_req_ready_in  = 1'($urandom());
        mem_resp_valid_in = 1'($urandom());
        mem_resp_data_in  = randLine();
        mem_resp_addr_in  = $urandom();
    endtask

    // One whole transaction starting from an idle arbiter; the winner and
    // all cycle positions come from the round-robin rule and the latency rules.
    task automatic runTransaction(input bit icReq, input bit dcReq,
                                  input logic [AW-1:0] icAddr, input logic [AW-1:0] dcAddr,
                                  input logic [DW-1:0] dcData, input bit dcWrite,
                                  input int readyDelay, input int respDelay);
        bit            winDc;
        bit            expWrite;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] respData;
        bit            last;
        winDc    = (icReq && dcReq) ? modelPtrDc : dcReq;
        expAddr  = winDc ? dcAddr : icAddr;
        expWrite = winDc && dcWrite;

        @(negedge clk);
        ic_req_in         = icReq;
        ic_addr_in        = icAddr;
        dc_req_in         = dcReq;
        dc_addr_in        = dcAddr;
        dc_data_in        = dcData;
        dc_write_in       = dcWrite;
        mem_req_ready_in  = 1'($urandom());
        mem_resp_valid_in = 1'($urandom());
        mem_resp_data_in  = randLine();
        mem_resp_addr_in  = $urandom();
        #1;
        checkOutput("idle busy", busy_out, 0);
        checkOutput("idle valid", mem_req_valid_out, 0);
        checkOutput("idle grants", {ic_grant_out, dc_grant_out}, 0);
        checkOutput("idle fills", {ic_fill_out, dc_fill_out}, 0);

        for (int k = 0; k <= readyDelay; k++) begin
            @(negedge clk);
            last              = (k == readyDelay);
            mem_req_ready_in  = last;
            mem_resp_valid_in = 1'($urandom());
            mem_resp_data_in  = randLine();
            #1;
            checkOutput("issue valid", mem_req_valid_out, 1);
            checkOutput("issue addr", mem_req_addr_out, expAddr);
            checkOutput("issue write", mem_req_write_out, expWrite);
            if (expWrite) checkOutput("issue data", mem_req_data_out, dcData);
            checkOutput("issue grants", {ic_grant_out, dc_grant_out},
                        {!winDc && last, winDc && last});
            checkOutput("issue fills", {ic_fill_out, dc_fill_out}, 0);
        end
        modelPtrDc = !winDc;

        if (!expWrite) begin
            for (int k = 0; k <= respDelay; k++) begin
                @(negedge clk);
                last              = (k == respDelay);
                respData          = randLine();
                mem_req_ready_in  = 1'($urandom());
                mem_resp_valid_in = last;
                mem_resp_data_in  = respData;
                mem_resp_addr_in  = last ? expAddr : AW'($urandom());
                #1;
                checkOutput("wait busy", busy_out, 1);
                checkOutput("wait valid", mem_req_valid_out, 0);
                checkOutput("wait req addr", mem_req_addr_out, 0);
                checkOutput("wait grants", {ic_grant_out, dc_grant_out}, 0);
                checkOutput("wait fills", {ic_fill_out, dc_fill_out},
                            {!winDc && last, winDc && last});
                if (last && winDc) begin
                    checkOutput("dc fill data", dc_fill_data_out, respData);
                    checkOutput("dc fill addr", dc_fill_addr_out, expAddr);
                end
                if (last && !winDc) begin
                    checkOutput("ic fill data", ic_fill_data_out, respData);
                    checkOutput("ic fill addr", ic_fill_addr_out, expAddr);
                end
            end
        end

        @(negedge clk);
        if (winDc) dc_req_in = 1'b0;
        else ic_req_in = 1'b0;
        mem_req_ready_in  = 1'($urandom());
        mem_resp_valid_in = 1'b1;
        mem_resp_data_in  = randLine();
        #1;
        checkOutput("done busy", busy_out, 1);
        checkOutput("done valid", mem_req_valid_out, 0);
        checkOutput("done grants", {ic_grant_out, dc_grant_out}, 0);
        checkOutput("done fills", {ic_fill_out, dc_fill_out}, 0);
    endtask

    initial begin
        logic [DW-1:0] deadBeef;
        logic [DW-1:0] wbData;
        bit            r1;
        bit            r2;
        deadBeef = DW'(32'hDEAD_BEEF);
        wbData   = DW'(16'h1234);

        // Reset held with random inputs
        reset      = 1'b0;
        modelPtrDc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus();
            #1;
            checkAllZero("reset");
        end
        @(negedge clk);
        reset             = 1'b1;
        ic_req_in         = 1'b0;
        dc_req_in         = 1'b0;
        mem_req_ready_in  = 1'b0;
        mem_resp_valid_in = 1'b0;
        #1;
        checkAllZero("release");
        @(negedge clk);
        #1;
        checkAllZero("release idle");

        // Simultaneous requests right after reset: dcache, icache, dcache
        runTransaction(1, 1, 'h200, 'h300, randLine(), 0, 0, 1);
        runTransaction(1, 1, 'h204, 'h304, randLine(), 0, 1, 0);
        runTransaction(1, 1, 'h208, 'h308, randLine(), 0, 0, 2);

        // Icache read with a delayed response
        runTransaction(1, 0, 'h40, 'h0, '0, 0, 0, 5);
        @(negedge clk);
        ic_req_in         = 1'b1;
        ic_addr_in        = 'h44;
        mem_req_ready_in  = 1'b1;
        mem_resp_valid_in = 1'b0;
        #1;
        checkOutput("post-read idle", busy_out, 0);
        @(negedge clk);
        #1;
        checkOutput("ic grant direct", ic_grant_out, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mem_req_ready_in  = 1'b0;
            mem_resp_valid_in = (k == 4);
            mem_resp_data_in  = deadBeef;
            mem_resp_addr_in  = 'h44;
            #1;
            checkOutput("ic fill pulse", ic_fill_out, (k == 4));
            checkOutput("dc fill quiet", dc_fill_out, 0);
        end
        checkOutput("ic fill deadbeef", ic_fill_data_out, deadBeef);
        @(negedge clk);
        ic_req_in         = 1'b0;
        mem_resp_valid_in = 1'b0;
        #1;
        checkOutput("ic read done", busy_out, 1);
        modelPtrDc = 1'b1;

        // Dcache write-back, then with back-pressure
        runTransaction(0, 1, 'h0, 'h80, wbData, 1, 0, 0);
        runTransaction(0, 1, 'h0, 'h84, randLine(), 1, 3, 0);
        runTransaction(1, 0, 'h88, 'h0, '0, 0, 3, 2);

        // Reset while waiting for a read response
        @(negedge clk);
        ic_req_in         = 1'b1;
        ic_addr_in        = 'h100;
        dc_req_in         = 1'b0;
        mem_req_ready_in  = 1'b1;
        mem_resp_valid_in = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("pre-reset grant", ic_grant_out, 1);
        @(negedge clk);
        mem_req_ready_in = 1'b0;
        #1;
        checkOutput("in wait", busy_out, 1);
        #1;
        reset = 1'b0;
        #1;
        checkAllZero("async reset");
        modelPtrDc = 1'b1;
        @(negedge clk);
        reset             = 1'b1;
        ic_req_in         = 1'b0;
        mem_resp_valid_in = 1'b1;
        mem_resp_data_in  = randLine();
        mem_resp_addr_in  = 'h100;
        #1;
        checkOutput("stale fill", {ic_fill_out, dc_fill_out}, 0);
        checkOutput("stale busy", busy_out, 0);
        runTransaction(1, 1, 'h104, 'h204, randLine(), 0, 1, 1);

        // Random traffic
        for (int i = 0; i < 30; i++) begin
            r1 = 1'($urandom());
            r2 = 1'($urandom());
            if (!r1 && !r2) r2 = 1'b1;
            runTransaction(r1, r2, AW'($urandom()), AW'($urandom()), randLine(),
                           1'($urandom()), int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 4)));
        end
        @(negedge clk);
        ic_req_in = 1'b0;
        dc_req_in = 1'b0;
        #1;
        checkOutput("final idle", busy_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
